// File: rtl/adder_arb_pkg.sv
// Shared types and helpers for the adder arbiter slice.
package adder_arb_pkg;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    // Index width that stays at least one bit wide for tiny requester counts.
    function automatic int id_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or above ptr, wrapping.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);

    logic [IW-1:0] k;

    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        k   = '0;
        for (int i = 0; i < N; i++) begin
            k = IW'((int'(ptr) + i) % N);
            if (!any && req[k]) begin
                any    = 1'b1;
                gnt[k] = 1'b1;
                idx    = k;
            end
        end
    end

endmodule

// File: rtl/adder_arbiter.sv
// Round-robin front end sharing one registered adder among several requesters,
// with a watchdog that turns a missing adder result into a tagged error response.
module adder_arbiter
    import adder_arb_pkg::*;
#(
    parameter int g_data_width = 8,
    parameter int g_num_req    = 4,
    parameter int g_timeout    = 8
) (
    input  logic                                i_clk,
    input  logic                                i_rst_n,
    input  logic [g_num_req-1:0]                i_req_valid,
    input  logic [g_num_req*g_data_width-1:0]   i_req_A,
    input  logic [g_num_req*g_data_width-1:0]   i_req_B,
    output logic [g_num_req-1:0]                o_req_ready,
    output logic                                o_add_valid,
    output logic [g_data_width-1:0]             o_add_A,
    output logic [g_data_width-1:0]             o_add_B,
    input  logic                                i_add_valid,
    input  logic [g_data_width:0]               i_add_C,
    output logic                                o_rsp_valid,
    output logic [id_width(g_num_req)-1:0]      o_rsp_id,
    output logic [g_data_width:0]               o_rsp_C,
    output logic                                o_rsp_err,
    input  logic                                i_rsp_ready,
    output logic                                o_busy
);

    localparam int IW = id_width(g_num_req);
    localparam int W  = g_data_width;

    state_t                        state;
    logic [IW-1:0]                 rr_ptr;
    logic [IW-1:0]                 lat_id;
    logic [W-1:0]                  lat_a;
    logic [W-1:0]                  lat_b;
    logic [W:0]                    result;
    logic                          err;
    logic [7:0]                    cnt;

    logic [g_num_req-1:0][W-1:0]   req_a;
    logic [g_num_req-1:0][W-1:0]   req_b;
    logic [g_num_req-1:0]          gnt;
    logic [IW-1:0]                 gnt_idx;
    logic                          gnt_any;

    assign req_a = i_req_A;
    assign req_b = i_req_B;

    rr_arbiter #(.N(g_num_req), .IW(IW)) u_rr (
        .req (i_req_valid),
        .ptr (rr_ptr),
        .gnt (gnt),
        .idx (gnt_idx),
        .any (gnt_any)
    );

    // Ready is gated by reset so nothing can appear accepted while held in reset.
    assign o_req_ready = (state == IDLE && i_rst_n) ? gnt : '0;
    assign o_add_A     = lat_a;
    assign o_add_B     = lat_b;
    assign o_rsp_id    = lat_id;
    assign o_rsp_C     = result;
    assign o_rsp_err   = err;
    assign o_busy      = (state != IDLE);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            lat_id      <= '0;
            lat_a       <= '0;
            lat_b       <= '0;
            result      <= '0;
            err         <= 1'b0;
            cnt         <= '0;
            o_add_valid <= 1'b0;
            o_rsp_valid <= 1'b0;
        end else begin
            o_add_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (gnt_any) begin
                        lat_a       <= req_a[gnt_idx];
                        lat_b       <= req_b[gnt_idx];
                        lat_id      <= gnt_idx;
                        o_add_valid <= 1'b1;
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    cnt   <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    if (i_add_valid) begin
                        result      <= i_add_C;
                        err         <= 1'b0;
                        o_rsp_valid <= 1'b1;
                        state       <= RESP;
                    end else begin
                        cnt <= cnt + 8'd1;
                        if (cnt == 8'(g_timeout - 1)) begin
                            result      <= '0;
                            err         <= 1'b1;
                            o_rsp_valid <= 1'b1;
                            state       <= RESP;
                        end
                    end
                end
                RESP: begin
                    if (i_rsp_ready) begin
                        o_rsp_valid <= 1'b0;
                        rr_ptr      <= (lat_id == IW'(g_num_req - 1)) ? '0 : lat_id + IW'(1);
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    a_ready_onehot: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        $onehot0(o_req_ready));

    a_rsp_hold: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        (o_rsp_valid && !i_rsp_ready) |=>
            (o_rsp_valid && $stable(o_rsp_id) && $stable(o_rsp_C) && $stable(o_rsp_err)));

endmodule

// File: tb/tb_adder_arbiter.sv
// Randomised bench for adder_arbiter with a behavioural adder and reference model.
module tb_adder_arbiter;

    localparam int W  = 8;
    localparam int N  = 4;
    localparam int TO = 8;
    localparam int IW = 2;

    logic              i_clk = 1'b0;
    logic              i_rst_n = 1'b0;
    logic [N-1:0]      i_req_valid;
    logic [N*W-1:0]    i_req_A, i_req_B;
    logic [N-1:0]      o_req_ready;
    logic              o_add_valid;
    logic [W-1:0]      o_add_A, o_add_B;
    logic              add_v;
    logic [W:0]        add_C;
    logic              o_rsp_valid;
    logic [IW-1:0]     o_rsp_id;
    logic [W:0]        o_rsp_C;
    logic              o_rsp_err;
    logic              i_rsp_ready;
    logic              o_busy;
    bit                adder_dead = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 i_clk = ~i_clk;

    adder_arbiter #(.g_data_width(W), .g_num_req(N), .g_timeout(TO)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_req_valid(i_req_valid), .i_req_A(i_req_A), .i_req_B(i_req_B),
        .o_req_ready(o_req_ready),
        .o_add_valid(o_add_valid), .o_add_A(o_add_A), .o_add_B(o_add_B),
        .i_add_valid(add_v), .i_add_C(add_C),
        .o_rsp_valid(o_rsp_valid), .o_rsp_id(o_rsp_id), .o_rsp_C(o_rsp_C),
        .o_rsp_err(o_rsp_err), .i_rsp_ready(i_rsp_ready), .o_busy(o_busy)
    );

    // One-cycle adder; adder_dead models an adder that never answers.
    always @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            add_v <= 1'b0;
            add_C <= '0;
        end else begin
            add_v <= o_add_valid && !adder_dead;
            add_C <= {1'b0, o_add_A} + {1'b0, o_add_B};
        end
    end

    function automatic logic [W:0] sum(input logic [W-1:0] a, input logic [W-1:0] b);
        return {1'b0, a} + {1'b0, b};
    endfunction

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle_inputs();
        i_req_valid = '0;
        i_req_A     = '0;
        i_req_B     = '0;
        i_rsp_ready = 1'b1;
    endtask

    task automatic set_req(input int k, input logic [W-1:0] a, input logic [W-1:0] b);
        i_req_valid[k]     = 1'b1;
        i_req_A[k*W +: W]  = a;
        i_req_B[k*W +: W]  = b;
    endtask

    task automatic do_reset();
        i_rst_n = 1'b0;
        idle_inputs();
        adder_dead = 1'b0;
        repeat (2) @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0;
        idle_inputs();
        i_req_valid = '1;
        #1;
        n_tests++;
        if (o_req_ready !== '0) begin n_fail++; $display("FAIL reset_ready got=%b exp=0", o_req_ready); end
        n_tests++;
        if ({o_add_valid, o_add_A, o_add_B} !== '0) begin
            n_fail++; $display("FAIL reset_add got=%b/%h/%h exp=0", o_add_valid, o_add_A, o_add_B);
        end
        n_tests++;
        if ({o_rsp_valid, o_rsp_id, o_rsp_C, o_rsp_err, o_busy} !== '0) begin
            n_fail++; $display("FAIL reset_rsp got v=%b id=%0d C=%h err=%b busy=%b exp all 0",
                               o_rsp_valid, o_rsp_id, o_rsp_C, o_rsp_err, o_busy);
        end
        i_req_valid = '0;
    endtask

    task automatic test_single();
        do_reset();
        set_req(2, 8'h12, 8'h34);
        #1;
        n_tests++;
        if (o_req_ready !== 4'b0100) begin n_fail++; $display("FAIL single_grant got=%b exp=0100", o_req_ready); end
        tick();
        i_req_valid = '0;
        n_tests++;
        if ({o_add_valid, o_add_A, o_add_B, o_busy} !== {1'b1, 8'h12, 8'h34, 1'b1}) begin
            n_fail++; $display("FAIL single_issue got v=%b A=%h B=%h busy=%b exp 1/12/34/1",
                               o_add_valid, o_add_A, o_add_B, o_busy);
        end
        tick();
        n_tests++;
        if ({o_add_valid, o_rsp_valid} !== 2'b00) begin
            n_fail++; $display("FAIL single_cycle2 got add_v=%b rsp_v=%b exp 0/0", o_add_valid, o_rsp_valid);
        end
        tick();
        n_tests++;
        if ({o_rsp_valid, o_rsp_id, o_rsp_C, o_rsp_err} !== {1'b1, 2'd2, 9'h046, 1'b0}) begin
            n_fail++; $display("FAIL single_rsp got v=%b id=%0d C=%h err=%b exp 1/2/046/0",
                               o_rsp_valid, o_rsp_id, o_rsp_C, o_rsp_err);
        end
        tick();
        n_tests++;
        if ({o_rsp_valid, o_busy} !== 2'b00) begin
            n_fail++; $display("FAIL single_done got rsp_v=%b busy=%b exp 0/0", o_rsp_valid, o_busy);
        end
        i_req_valid = '1;
        #1;
        n_tests++;
        if (o_req_ready !== 4'b1000) begin n_fail++; $display("FAIL single_ptr got=%b exp=1000", o_req_ready); end
        i_req_valid = '0;
    endtask

    task automatic test_max();
        int c;
        set_req(3, 8'hFF, 8'hFF);
        tick();
        i_req_valid = '0;
        c = 0;
        while (!o_rsp_valid && c < 20) begin tick(); c++; end
        n_tests++;
        if ({o_rsp_valid, o_rsp_id, o_rsp_C, o_rsp_err} !== {1'b1, 2'd3, 9'h1FE, 1'b0}) begin
            n_fail++; $display("FAIL max_operands got v=%b id=%0d C=%h err=%b exp 1/3/1fe/0",
                               o_rsp_valid, o_rsp_id, o_rsp_C, o_rsp_err);
        end
        tick();
    endtask

    task automatic test_round_robin();
        int exp_order[5] = '{0, 1, 2, 3, 0};
        logic [W-1:0] opa[N];
        logic [W-1:0] opb[N];
        int c, k;
        logic [W:0] exp_c;
        do_reset();
        for (int i = 0; i < N; i++) begin
            opa[i] = W'($urandom);
            opb[i] = W'($urandom);
            set_req(i, opa[i], opb[i]);
        end
        for (int op = 0; op < 5; op++) begin
            k = exp_order[op];
            #1;
            n_tests++;
            if (o_req_ready !== N'(1 << k)) begin
                n_fail++; $display("FAIL rr_grant op=%0d got=%b exp=%b", op, o_req_ready, N'(1 << k));
            end
            exp_c = sum(opa[k], opb[k]);
            tick();
            opa[k] = W'($urandom);
            opb[k] = W'($urandom);
            set_req(k, opa[k], opb[k]);
            c = 0;
            while (!o_rsp_valid && c < 20) begin
                n_tests++;
                if (o_req_ready !== '0) begin n_fail++; $display("FAIL rr_busy_ready got=%b exp=0", o_req_ready); end
                tick();
                c++;
            end
            n_tests++;
            if ({o_rsp_valid, o_rsp_id, o_rsp_C, o_rsp_err} !== {1'b1, IW'(k), exp_c, 1'b0}) begin
                n_fail++; $display("FAIL rr_rsp op=%0d got v=%b id=%0d C=%h err=%b exp 1/%0d/%h/0",
                                   op, o_rsp_valid, o_rsp_id, o_rsp_C, o_rsp_err, k, exp_c);
            end
            tick();
        end
        i_req_valid = '0;
    endtask

    task automatic test_backpressure();
        logic [W-1:0] a, b;
        int c;
        a = W'($urandom);
        b = W'($urandom);
        i_rsp_ready = 1'b0;
        set_req(1, a, b);
        tick();
        i_req_valid = '1;
        c = 0;
        while (!o_rsp_valid && c < 20) begin tick(); c++; end
        for (int i = 0; i < 5; i++) begin
            n_tests++;
            if ({o_rsp_valid, o_rsp_id, o_rsp_C, o_rsp_err, o_req_ready} !==
                {1'b1, 2'd1, sum(a, b), 1'b0, 4'b0000}) begin
                n_fail++; $display("FAIL bp_hold cyc=%0d got v=%b id=%0d C=%h err=%b rdy=%b exp 1/1/%h/0/0000",
                                   i, o_rsp_valid, o_rsp_id, o_rsp_C, o_rsp_err, o_req_ready, sum(a, b));
            end
            tick();
        end
        i_rsp_ready = 1'b1;
        tick();
        n_tests++;
        if ({o_rsp_valid, o_req_ready} !== {1'b0, 4'b0100}) begin
            n_fail++; $display("FAIL bp_release got v=%b rdy=%b exp 0/0100", o_rsp_valid, o_req_ready);
        end
        i_req_valid = '0;
    endtask

    task automatic test_timeout();
        logic [W-1:0] a, b;
        int c;
        adder_dead = 1'b1;
        set_req(2, 8'h55, 8'h66);
        tick();
        i_req_valid = '0;
        c = 1;
        while (!o_rsp_valid && c < 30) begin tick(); c++; end
        n_tests++;
        if (c !== 10) begin n_fail++; $display("FAIL timeout_latency got=%0d exp=10", c); end
        n_tests++;
        if ({o_rsp_valid, o_rsp_id, o_rsp_C, o_rsp_err} !== {1'b1, 2'd2, 9'h000, 1'b1}) begin
            n_fail++; $display("FAIL timeout_rsp got v=%b id=%0d C=%h err=%b exp 1/2/000/1",
                               o_rsp_valid, o_rsp_id, o_rsp_C, o_rsp_err);
        end
        tick();
        adder_dead = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
        set_req(3, a, b);
        tick();
        i_req_valid = '0;
        c = 0;
        while (!o_rsp_valid && c < 20) begin tick(); c++; end
        n_tests++;
        if ({o_rsp_valid, o_rsp_id, o_rsp_C, o_rsp_err} !== {1'b1, 2'd3, sum(a, b), 1'b0}) begin
            n_fail++; $display("FAIL timeout_recover got v=%b id=%0d C=%h err=%b exp 1/3/%h/0",
                               o_rsp_valid, o_rsp_id, o_rsp_C, o_rsp_err, sum(a, b));
        end
        tick();
    endtask

    task automatic test_reset_mid();
        int c;
        set_req(1, 8'h01, 8'h02);
        tick();
        i_req_valid = '0;
        repeat (4) tick();
        adder_dead = 1'b1;
        set_req(2, 8'h10, 8'h20);
        tick();
        i_req_valid = '0;
        tick();
        tick();
        n_tests++;
        if (o_busy !== 1'b1) begin n_fail++; $display("FAIL midrst_pre got busy=%b exp=1", o_busy); end
        #2;
        i_rst_n = 1'b0;
        #1;
        n_tests++;
        if ({o_req_ready, o_add_valid, o_add_A, o_add_B, o_rsp_valid, o_rsp_id, o_rsp_C, o_rsp_err, o_busy} !== '0) begin
            n_fail++; $display("FAIL midrst_outputs got rdy=%b av=%b A=%h B=%h v=%b id=%0d C=%h err=%b busy=%b exp all 0",
                               o_req_ready, o_add_valid, o_add_A, o_add_B, o_rsp_valid, o_rsp_id, o_rsp_C, o_rsp_err, o_busy);
        end
        #1;
        i_rst_n    = 1'b1;
        adder_dead = 1'b0;
        set_req(0, 8'hA0, 8'h0B);
        set_req(2, 8'h11, 8'h22);
        #1;
        n_tests++;
        if (o_req_ready !== 4'b0001) begin n_fail++; $display("FAIL midrst_grant got=%b exp=0001", o_req_ready); end
        tick();
        i_req_valid = '0;
        c = 0;
        while (!o_rsp_valid && c < 20) begin tick(); c++; end
        n_tests++;
        if ({o_rsp_valid, o_rsp_id, o_rsp_C, o_rsp_err} !== {1'b1, 2'd0, 9'h0AB, 1'b0}) begin
            n_fail++; $display("FAIL midrst_rsp got v=%b id=%0d C=%h err=%b exp 1/0/0ab/0",
                               o_rsp_valid, o_rsp_id, o_rsp_C, o_rsp_err);
        end
        tick();
    endtask

    // Reference model: pending-operation queue plus round-robin pointer.
    task automatic test_random();
        int         ptr_m = 0;
        bit         idle_m = 1'b1;
        bit         go_idle = 1'b0;
        int         busy_cyc = 0;
        int         g;
        logic [N-1:0] exp_rdy;
        int         q_id[$];
        logic [W:0] q_c[$];
        logic [W-1:0] a, b;
        do_reset();
        for (int cyc = 0; cyc < 400; cyc++) begin
            i_req_valid = N'($urandom);
            for (int k = 0; k < N; k++) begin
                i_req_A[k*W +: W] = W'($urandom);
                i_req_B[k*W +: W] = W'($urandom);
            end
            i_rsp_ready = ($urandom_range(0, 3) != 0);
            #1;
            exp_rdy = '0;
            g = -1;
            if (idle_m) begin
                for (int i = 0; i < N; i++)
                    if (g < 0 && i_req_valid[(ptr_m + i) % N]) g = (ptr_m + i) % N;
                if (g >= 0) exp_rdy[g] = 1'b1;
            end
            n_tests++;
            if (o_req_ready !== exp_rdy) begin
                n_fail++; $display("FAIL rand_ready cyc=%0d got=%b exp=%b", cyc, o_req_ready, exp_rdy);
            end
            if (g >= 0) begin
                a = i_req_A[g*W +: W];
                b = i_req_B[g*W +: W];
                q_id.push_back(g);
                q_c.push_back(sum(a, b));
                idle_m   = 1'b0;
                busy_cyc = 0;
            end
            if (o_rsp_valid) begin
                n_tests++;
                if (q_id.size() == 0) begin
                    n_fail++; $display("FAIL rand_rsp cyc=%0d got unexpected response id=%0d exp none", cyc, o_rsp_id);
                end else begin
                    if ({o_rsp_id, o_rsp_C, o_rsp_err} !== {IW'(q_id[0]), q_c[0], 1'b0}) begin
                        n_fail++; $display("FAIL rand_rsp cyc=%0d got id=%0d C=%h err=%b exp %0d/%h/0",
                                           cyc, o_rsp_id, o_rsp_C, o_rsp_err, q_id[0], q_c[0]);
                    end
                    if (i_rsp_ready) begin
                        ptr_m   = (q_id[0] + 1) % N;
                        void'(q_id.pop_front());
                        void'(q_c.pop_front());
                        go_idle = 1'b1;
                    end
                end
            end
            if (!idle_m) busy_cyc++;
            if (busy_cyc > 40) begin
                n_tests++;
                n_fail++;
                $display("FAIL rand_stall cyc=%0d busy for %0d cycles exp response", cyc, busy_cyc);
                break;
            end
            tick();
            if (go_idle) idle_m = 1'b1;
            go_idle = 1'b0;
        end
        idle_inputs();
        repeat (12) tick();
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1);
    end

    initial begin
        idle_inputs();
        test_reset();
        test_single();
        test_max();
        test_round_robin();
        test_backpressure();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/adder_arbiter.md
Name: adder_arbiter

Overview:
- Shares one simple_adder datapath (i_valid |=> o_valid, o_C is g_data_width+1 bits) among g_num_req requesters.
- Round-robin arbitration; one operation in flight at a time.
- Per-requester valid/ready request channel, a single tagged response channel, and a watchdog timeout on the adder result.
- Sits between client blocks and the adder instance in the top level.

Parameters:
- g_data_width, 8, operand width; adder result is g_data_width+1 bits.
- g_num_req, 4, number of requesters (2..16).
- g_timeout, 8, cycles to wait in WAIT for i_add_valid before declaring an error (1..255).

Ports:
- i_clk  in  1  clock, all state updates on rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_req_valid  in  g_num_req  per-requester request valid.
- i_req_A  in  g_num_req*g_data_width  packed operand A; requester k uses slice [k*W +: W].
- i_req_B  in  g_num_req*g_data_width  packed operand B, same packing.
- o_req_ready  out  g_num_req  one-hot accept; request k transfers when i_req_valid[k] && o_req_ready[k].
- o_add_valid  out  1  drives adder i_valid.
- o_add_A  out  g_data_width  drives adder i_A.
- o_add_B  out  g_data_width  drives adder i_B.
- i_add_valid  in  1  adder o_valid.
- i_add_C  in  g_data_width+1  adder o_C.
- o_rsp_valid  out  1  response valid.
- o_rsp_id  out  $clog2(g_num_req)  index of the requester owning the response.
- o_rsp_C  out  g_data_width+1  sum.
- o_rsp_err  out  1  timeout flag; qualified by o_rsp_valid.
- i_rsp_ready  in  1  response consumer ready.
- o_busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (async, i_rst_n=0): state=IDLE, rr_ptr=0, all outputs 0, operand/result registers 0, timeout counter 0.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE, arbitration:
  - grant = first k with i_req_valid[k], searching from rr_ptr upward with wrap-around.
  - o_req_ready is combinational: one-hot at grant when any valid is set, else all zero.
  - On transfer: latch A, B, id; go to ISSUE.
  - o_req_ready is 0 in every other state.
- ISSUE:
  - o_add_valid=1 for exactly one cycle with the latched operands; o_add_A/B hold their values in all states.
  - Timeout counter cleared. Next state WAIT.
- WAIT:
  - If i_add_valid: capture i_add_C, err=0, go to RESP.
  - Else increment the counter. When it reaches g_timeout: result=0, err=1, go to RESP.
  - i_add_valid outside WAIT is ignored.
- RESP:
  - o_rsp_valid=1; o_rsp_id, o_rsp_C and o_rsp_err stay stable until i_rsp_ready.
  - On handshake: rr_ptr = (id+1) mod g_num_req, go to IDLE.
  - o_rsp_valid is registered (asserted from state entry).
- Latency and throughput:
  - Nominal case: accept at cycle 0, o_add_valid at cycle 1, adder result at cycle 2, o_rsp_valid at cycle 3.
  - Minimum 4 cycles per operation when i_rsp_ready is held high.
- Arithmetic: no truncation; o_rsp_C is the full W+1-bit adder result. Maximum legal value is 2^(W+1)-2.
- Requester dropping valid before grant: not an error; it is simply not selected.
- Simultaneous requests: only the one at or after rr_ptr is granted; the others wait. Starvation-free, with a bound of g_num_req-1 intervening operations.
- Reset mid-operation: returns to IDLE. The in-flight operation is lost and no response is emitted.

Decomposition:
- Package adder_arb_pkg:
  - state_t enum {IDLE, ISSUE, WAIT, RESP}.
  - Function clog2-safe id width (minimum 1).
- Sub-module rr_arbiter: combinational round-robin priority pick.
  - Inputs: req vector, rr_ptr.
  - Outputs: one-hot grant and binary index.
- Parent holds the FSM, the registers and the timeout counter.

Test Plan:
- Single request: k=2, A=0x12, B=0x34, adder responding after 1 cycle, i_rsp_ready=1 → o_add_valid at cycle 1; o_rsp_valid at cycle 3 with id=2, C=0x046, err=0; rr_ptr becomes 3.
- Max operands: A=B=0xFF → o_rsp_C=0x1FE, err=0.
- All 4 requesters valid continuously from reset → grants in order 0,1,2,3,0; each response carries the matching id and sum; no o_req_ready while busy.
- Backpressure: i_rsp_ready=0 for 5 cycles in RESP → o_rsp_valid, id, C and err held stable; no new o_req_ready; completes one cycle after ready rises.
- Timeout: adder model never asserts o_valid, g_timeout=8 → o_rsp_valid with err=1 and C=0 after 8 WAIT cycles; the next request is then served normally.
- Async reset asserted in WAIT → all outputs 0 immediately; after release, a request to k=0 is granted with rr_ptr=0.
